// File: rtl/cp_remover.sv
// rtl/cp_remover.sv - streaming OFDM cyclic-prefix remover with FWFT output FIFO
module cp_remover #(
    parameter int WIDTH      = 16,
    parameter int NFFT       = 64,
    parameter int NCP        = 16,
    parameter int BACKOFF    = 0,
    parameter int NSYM       = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int OFF_W      = 7,
    localparam int SYM_W     = (NSYM > 1) ? $clog2(NSYM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OFF_W-1:0] offset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_re,
    input  logic [WIDTH-1:0] data_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out_re,
    output logic [WIDTH-1:0] data_out_im,
    output logic             out_last,
    output logic [SYM_W-1:0] out_sym,
    output logic             busy,
    output logic             done
);

    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CMAX     = (NFFT > NCP) ? NFFT : NCP;
    localparam int CBITS    = $clog2(CMAX + 1);
    localparam int CNT_W    = (OFF_W > CBITS) ? OFF_W : CBITS;
    localparam int DROP_LEN = NCP - BACKOFF;

    localparam logic [CNT_W-1:0] C_KEEP_LAST = CNT_W'(NFFT - 1);
    localparam logic [CNT_W-1:0] C_DROP_LAST = CNT_W'(DROP_LEN - 1);
    localparam logic [CNT_W-1:0] C_TAIL_LAST = CNT_W'(BACKOFF - 1);
    localparam logic [SYM_W-1:0] C_SYM_LAST  = SYM_W'(NSYM - 1);
    localparam logic [AW:0]      C_DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_DROP,
        S_KEEP,
        S_TAIL
    } state_t;

    // Entry point of every symbol: the CP drop, or straight to KEEP when the
    // back-off swallows the whole prefix.
    localparam state_t S_CP = (DROP_LEN > 0) ? S_DROP : S_KEEP;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SYM_W-1:0]   r_sym;
    logic [SYM_W-1:0]   w_sym_nxt;
    logic [OFF_W-1:0]   r_off;
    logic [CNT_W-1:0]   w_off_last;

    logic               w_in_ready;
    logic               w_hs;
    logic               w_push;
    logic               w_last;
    logic               w_done;

    logic [WIDTH-1:0]   r_mem_re   [FIFO_DEPTH];
    logic [WIDTH-1:0]   r_mem_im   [FIFO_DEPTH];
    logic               r_mem_last [FIFO_DEPTH];
    logic [SYM_W-1:0]   r_mem_sym  [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [AW-1:0]      w_rd_nxt;
    logic [AW:0]        w_count_nxt;
    logic               w_not_full;
    logic               w_out_valid;
    logic               w_pop;

    logic [WIDTH-1:0]   r_out_re;
    logic [WIDTH-1:0]   r_out_im;
    logic               r_out_last;
    logic [SYM_W-1:0]   r_out_sym;
    logic [WIDTH-1:0]   w_head_re;
    logic [WIDTH-1:0]   w_head_im;
    logic               w_head_last;
    logic [SYM_W-1:0]   w_head_sym;

    // Only KEEP can be throttled by the FIFO; every other state drains input freely.
    assign w_not_full  = (r_count != C_DEPTH);
    assign w_in_ready  = (r_state == S_KEEP) ? w_not_full : 1'b1;
    assign w_hs        = in_valid & w_in_ready;
    assign w_off_last  = CNT_W'(r_off) - CNT_W'(1);

    // Next-state, sample counter and symbol counter; counters move only on handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym;
        w_push      = 1'b0;
        w_last      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_nxt   = '0;
                    w_sym_nxt   = '0;
                    w_state_nxt = (offset != '0) ? S_SKIP : S_CP;
                end
            end
            S_SKIP: begin
                if (w_hs) begin
                    if (r_cnt == w_off_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_CP;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DROP: begin
                if (w_hs) begin
                    if (r_cnt == C_DROP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_KEEP;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_KEEP: begin
                if (w_hs) begin
                    w_push = 1'b1;
                    if (r_cnt == C_KEEP_LAST) begin
                        w_last    = 1'b1;
                        w_cnt_nxt = '0;
                        if (r_sym == C_SYM_LAST) begin
                            // Final symbol ends the frame; any tail is discarded by IDLE.
                            w_done      = 1'b1;
                            w_sym_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_sym_nxt   = r_sym + SYM_W'(1);
                            w_state_nxt = (BACKOFF > 0) ? S_TAIL : S_CP;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_TAIL: begin
                if (w_hs) begin
                    if (r_cnt == C_TAIL_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_CP;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_sym_nxt   = '0;
            end
        endcase
    end

    // FSM state, counters and the offset latched when a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sym   <= '0;
            r_off   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sym   <= w_sym_nxt;
            if (r_state == S_IDLE && start) begin
                r_off <= offset;
            end
        end
    end

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & out_ready;
    assign w_rd_nxt    = r_rd_ptr + AW'(w_pop);
    assign w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    // Head after this cycle's push/pop: the incoming sample bypasses storage
    // when it lands on an otherwise empty FIFO.
    always_comb begin
        w_head_re   = r_mem_re[w_rd_nxt];
        w_head_im   = r_mem_im[w_rd_nxt];
        w_head_last = r_mem_last[w_rd_nxt];
        w_head_sym  = r_mem_sym[w_rd_nxt];
        if (w_push && (w_rd_nxt == r_wr_ptr)) begin
            w_head_re   = data_re;
            w_head_im   = data_im;
            w_head_last = w_last;
            w_head_sym  = r_sym;
        end
    end

    // FIFO storage; contents are only observable through the head register.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_re[r_wr_ptr]   <= data_re;
            r_mem_im[r_wr_ptr]   <= data_im;
            r_mem_last[r_wr_ptr] <= w_last;
            r_mem_sym[r_wr_ptr]  <= r_sym;
        end
    end

    // FIFO pointers, occupancy and the registered head, which holds when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_re   <= '0;
            r_out_im   <= '0;
            r_out_last <= 1'b0;
            r_out_sym  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != '0) begin
                r_out_re   <= w_head_re;
                r_out_im   <= w_head_im;
                r_out_last <= w_head_last;
                r_out_sym  <= w_head_sym;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign data_out_re = r_out_re;
    assign data_out_im = r_out_im;
    assign out_last    = r_out_last;
    assign out_sym     = r_out_sym;
    assign busy        = (r_state != S_IDLE);
    assign done        = w_done;

endmodule

// File: doc/cp_remover.md
Name: cp_remover

Overview:
- Streaming OFDM cyclic-prefix remover. Sits between the sync/timing stage and the FFT.
- After a start pulse carrying the symbol timing offset, it skips the offset samples. It then repeatedly drops each symbol's CP (less a configurable back-off), keeps NFFT samples and drops the back-off tail, for NSYM symbols.
- Kept samples pass through an output FIFO with valid/ready backpressure toward the FFT.

Parameters:
- WIDTH, 16, bit width of each of re/im.
- NFFT, 64, useful samples kept per symbol.
- NCP, 16, cyclic-prefix length in samples.
- BACKOFF, 0, samples of the window moved into the CP (0..NCP-1); guards against late timing.
- NSYM, 6, symbols processed per start (>=1).
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2).
- OFF_W, 7, width of the offset input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- offset  in  OFF_W  samples to discard before symbol 0's CP; latched on accepted start.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid & in_ready.
- data_re  in  WIDTH  input real part.
- data_im  in  WIDTH  input imaginary part.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- data_out_re  out  WIDTH  output real part.
- data_out_im  out  WIDTH  output imaginary part.
- out_last  out  1  marks the NFFT-th sample of a symbol.
- out_sym  out  clog2(NSYM)  symbol index of the head sample.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the last kept sample of the frame enters the FIFO.

Behaviour:
- Reset:
  - State is IDLE; all counters are 0; FIFO is empty.
  - out_valid=0, data_out_re/im=0, out_last=0, out_sym=0, busy=0, done=0.
  - Reset mid-frame discards the FIFO contents and the frame with no further outputs.
- FSM states: IDLE, SKIP, DROP, KEEP, TAIL.
  - IDLE: in_ready=1 and samples are discarded. On start, offset is latched. Next state is SKIP if offset>0, else DROP.
  - SKIP: in_ready=1. Counts accepted samples; after offset samples, goes to DROP.
  - DROP: in_ready=1. Discards NCP-BACKOFF accepted samples, then goes to KEEP. If NCP-BACKOFF=0, goes directly to KEEP.
  - KEEP: in_ready = (fifo_count<FIFO_DEPTH). Each accepted sample is pushed. The NFFT-th push carries last=1, then the FSM goes to TAIL (BACKOFF>0) or the next state.
  - TAIL: in_ready=1. Discards BACKOFF samples.
  - After a symbol: sym_cnt increments. If sym_cnt reaches NSYM-1, the FSM pulses done (on the cycle of the final KEEP push) and returns to IDLE; otherwise it goes to DROP.
- start outside IDLE is ignored. Offset has no effect after latching.
- Sample counter advances only on accepted handshakes. in_valid=0 stalls every state.
- FIFO behaviour:
  - First-word-fall-through; outputs are the registered head entry.
  - Latency: a KEEP sample accepted at edge k is visible on out_* after edge k with out_valid=1, if the FIFO was empty.
  - Simultaneous push and pop when full is not allowed (in_ready=0 when full). Simultaneous push and pop otherwise leaves the count unchanged.
  - Pop occurs on out_valid & out_ready. When empty, out_valid=0 and data holds its last value.
- Data passes unmodified: no arithmetic, full WIDTH.
- Frame ends with the FIFO possibly non-empty. A new start in IDLE is allowed while the FIFO drains; ordering is preserved.

Test Plan:
- Default parameters with NSYM=2, offset=3, ramp input (re=n, im=-n), out_ready=1, in_valid=1 -> 128 outputs. Sym0 re=19..82 with out_last at 82. Sym1 re=99..162, out_sym=1, out_last at 162. done pulses once. Then busy=0.
- BACKOFF=4, offset=0, NSYM=1 -> outputs re=12..75; samples 76..79 are dropped.
- FIFO_DEPTH=8, out_ready=0 for 30 cycles during KEEP -> in_ready falls after 8 pushes. After out_ready=1, all 64 samples arrive in order with no loss or duplication.
- in_valid toggling 1/0 every cycle, offset=5 -> same output sequence as the continuous case (first re=21).
- start re-pulsed in the middle of sym0 -> ignored; output identical to the single-start run.
- rst asserted during KEEP of sym1 -> out_valid=0 and busy=0 immediately. A fresh start afterwards produces sym0 from the new offset.
